// File: rtl/ball_collision_resolve.sv
// Equal-mass elastic collision resolver for one ball pair.
// Computes the impulse factor with a bit-serial restoring divider, then applies it to both velocities.
module ball_collision_resolve #(
    parameter int N    = 32,
    parameter int FRAC = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [N-1:0] x0,
    input  logic signed [N-1:0] y0,
    input  logic signed [N-1:0] x1,
    input  logic signed [N-1:0] y1,
    input  logic signed [N-1:0] vx0,
    input  logic signed [N-1:0] vy0,
    input  logic signed [N-1:0] vx1,
    input  logic signed [N-1:0] vy1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] nvx0,
    output logic signed [N-1:0] nvy0,
    output logic signed [N-1:0] nvx1,
    output logic signed [N-1:0] nvy1,
    output logic                skipped
);
    localparam int W  = 3 * N;
    localparam int CW = $clog2(N);

    typedef enum logic [2:0] {IDLE, PREP, DIV, APPLY, DONE} state_t;
    state_t state, state_next;

    logic signed [N-1:0] x0_r, y0_r, x1_r, y1_r, vx0_r, vy0_r, vx1_r, vy1_r;
    logic signed [N-1:0] dx_r, dy_r;
    logic [W-1:0]        rem_r, div_r;
    logic [N-2:0]        q_r;
    logic [CW-1:0]       cnt_r;

    logic signed [N-1:0] dx_c, dy_c, dvx_c, dvy_c;
    logic signed [2*N:0] dx_e, dy_e, dvx_e, dvy_e, dist2_c, dot_c, abs_dot_c;
    logic [W-1:0]        num_c, den_full_c;
    logic                skip_c, sat_c;

    logic signed [2*N-1:0] q_e, dxa_e, dya_e, prod_x, prod_y;
    logic signed [N-1:0]   ax_c, ay_c;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);

    // Full-precision geometry; the saturation test is done at divider width so no bits are lost
    always_comb begin
        dx_c       = x0_r - x1_r;
        dy_c       = y0_r - y1_r;
        dvx_c      = vx0_r - vx1_r;
        dvy_c      = vy0_r - vy1_r;
        dx_e       = {{(N+1){dx_c[N-1]}}, dx_c};
        dy_e       = {{(N+1){dy_c[N-1]}}, dy_c};
        dvx_e      = {{(N+1){dvx_c[N-1]}}, dvx_c};
        dvy_e      = {{(N+1){dvy_c[N-1]}}, dvy_c};
        dist2_c    = dx_e * dx_e + dy_e * dy_e;
        dot_c      = dvx_e * dx_e + dvy_e * dy_e;
        abs_dot_c  = -dot_c;
        num_c      = {{(N-1-FRAC){1'b0}}, abs_dot_c, {FRAC{1'b0}}};
        den_full_c = {dist2_c, {(N-1){1'b0}}};
        skip_c     = !dot_c[2*N] || (dist2_c == '0);
        sat_c      = (num_c >= den_full_c);
    end

    always_comb begin
        q_e    = {{(N+1){1'b0}}, q_r};
        dxa_e  = {{N{dx_r[N-1]}}, dx_r};
        dya_e  = {{N{dy_r[N-1]}}, dy_r};
        prod_x = q_e * dxa_e;
        prod_y = q_e * dya_e;
        ax_c   = N'(prod_x >>> FRAC);
        ay_c   = N'(prod_y >>> FRAC);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = PREP;
            PREP:    state_next = (skip_c || sat_c) ? APPLY : DIV;
            DIV:     if (cnt_r == CW'(N-2)) state_next = APPLY;
            APPLY:   state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Divisor starts at dist2<<(N-2) and shifts right, yielding one quotient bit per cycle MSB first
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_r <= '0; y0_r <= '0; x1_r <= '0; y1_r <= '0;
            vx0_r <= '0; vy0_r <= '0; vx1_r <= '0; vy1_r <= '0;
            dx_r <= '0; dy_r <= '0;
            rem_r <= '0; div_r <= '0; q_r <= '0; cnt_r <= '0;
            nvx0 <= '0; nvy0 <= '0; nvx1 <= '0; nvy1 <= '0;
            skipped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x0_r <= x0; y0_r <= y0; x1_r <= x1; y1_r <= y1;
                        vx0_r <= vx0; vy0_r <= vy0; vx1_r <= vx1; vy1_r <= vy1;
                        skipped <= 1'b0;
                    end
                end
                PREP: begin
                    dx_r  <= dx_c;
                    dy_r  <= dy_c;
                    rem_r <= num_c;
                    div_r <= {1'b0, dist2_c, {(N-2){1'b0}}};
                    cnt_r <= '0;
                    if (skip_c) begin
                        q_r     <= '0;
                        skipped <= 1'b1;
                    end else if (sat_c) begin
                        q_r <= '1;
                    end else begin
                        q_r <= '0;
                    end
                end
                DIV: begin
                    if (rem_r >= div_r) begin
                        rem_r <= rem_r - div_r;
                        q_r   <= {q_r[N-3:0], 1'b1};
                    end else begin
                        q_r   <= {q_r[N-3:0], 1'b0};
                    end
                    div_r <= div_r >> 1;
                    cnt_r <= cnt_r + CW'(1);
                end
                APPLY: begin
                    nvx0 <= vx0_r + ax_c;
                    nvy0 <= vy0_r + ay_c;
                    nvx1 <= vx1_r - ax_c;
                    nvy1 <= vy1_r - ay_c;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ball_collision_resolve.sv
// Scoreboard bench for ball_collision_resolve: driver queues expected results, monitor checks them.
module tb_ball_collision_resolve;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [31:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic signed [31:0] vx0 = '0, vy0 = '0, vx1 = '0, vy1 = '0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic signed [31:0] nvx0, nvy0, nvx1, nvy1;
    logic skipped;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic signed [31:0] nvx0, nvy0, nvx1, nvy1;
        logic               skipped;
        int                 lat;
        longint             accept_t;
    } exp_t;

    exp_t sb[$];

    ball_collision_resolve #(.N(32), .FRAC(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .vx0(vx0), .vy0(vy0), .vx1(vx1), .vy1(vy1),
        .out_valid(out_valid), .out_ready(out_ready),
        .nvx0(nvx0), .nvy0(nvy0), .nvx1(nvx1), .nvy1(nvy1),
        .skipped(skipped)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic exp_t mk(input int a, input int b, input int c, input int d,
                                input logic s, input int lat);
        exp_t e;
        e.nvx0 = a; e.nvy0 = b; e.nvx1 = c; e.nvy1 = d;
        e.skipped = s; e.lat = lat; e.accept_t = 0;
        return e;
    endfunction

    task automatic apply_stimulus(input int ax0, input int ay0, input int ax1, input int ay1,
                                  input int avx0, input int avy0, input int avx1, input int avy1,
                                  input exp_t e, input bit push);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1");
            return;
        end
        x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
        vx0 = avx0; vy0 = avy0; vx1 = avx1; vy1 = avy1;
        in_valid = 1'b1;
        @(posedge clk);
        e.accept_t = longint'($time);
        if (push) sb.push_back(e);
        #1;
        in_valid = 1'b0;
        x0 = 32'h5A5A_1234; y0 = -77; x1 = 999; y1 = 32'h7FFF_0000;
        vx0 = 13; vy0 = -31; vx1 = 32'h8000_0001; vy1 = 4242;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: pending got %0d, expected 0", sb.size());
        end
    endtask

    // Monitor: compares each presented result against the oldest queued expectation
    initial begin
        exp_t   e;
        logic   prev_valid;
        longint rise_t;
        prev_valid = 1'b0;
        rise_t = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) rise_t = longint'($time) - 5;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_output: got out_valid 1, expected 0");
                    end else begin
                        e = sb.pop_front();
                        check_output("nvx0", nvx0, e.nvx0);
                        check_output("nvy0", nvy0, e.nvy0);
                        check_output("nvx1", nvx1, e.nvx1);
                        check_output("nvy1", nvy1, e.nvy1);
                        check_output("skipped", skipped, e.skipped);
                        check_output("latency", (rise_t - e.accept_t) / 10, e.lat);
                    end
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check_output("in_ready_in_rst", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_nvx0", nvx0, 0);
        check_output("rst_nvy1", nvy1, 0);
        check_output("rst_skipped", skipped, 0);
        check_output("rst_in_ready", in_ready, 1);

        // Head-on, glancing, negative-coordinate divide, separating, coincident, saturate
        apply_stimulus(0, 0, 10, 0, 5, 0, -5, 0, mk(-5, 0, 5, 0, 1'b0, 33), 1'b1);
        wait_drain();
        apply_stimulus(0, 0, 3, 4, 5, 0, 0, 0, mk(3, -3, 2, 3, 1'b0, 33), 1'b1);
        wait_drain();
        apply_stimulus(-2, 1, 1, -3, 0, 0, -2, 0, mk(-1, 0, -1, 0, 1'b0, 33), 1'b1);
        wait_drain();
        apply_stimulus(0, 0, 10, 0, -5, 0, 5, 0, mk(-5, 0, 5, 0, 1'b1, 2), 1'b1);
        wait_drain();
        apply_stimulus(7, 7, 7, 7, 3, -2, -4, 6, mk(3, -2, -4, 6, 1'b1, 2), 1'b1);
        wait_drain();
        apply_stimulus(0, 0, 1, 0, 100000, 0, 0, 0, mk(67232, 0, 32768, 0, 1'b0, 2), 1'b1);
        wait_drain();

        // Backpressure: result must stay put and in_ready low while the consumer stalls
        @(posedge clk);
        #1 out_ready = 1'b0;
        apply_stimulus(0, 0, 3, 4, 5, 0, 0, 0, mk(3, -3, 2, 3, 1'b0, 33), 1'b1);
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        check_output("bp_out_valid_seen", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("bp_hold_valid", out_valid, 1);
            check_output("bp_hold_nvx0", nvx0, 3);
            check_output("bp_hold_nvy0", nvy0, -3);
            check_output("bp_hold_nvx1", nvx1, 2);
            check_output("bp_hold_nvy1", nvy1, 3);
            check_output("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("bp_release_in_ready", in_ready, 1);
        check_output("bp_release_out_valid", out_valid, 0);
        wait_drain();

        // Reset in the middle of a divide discards the pair
        apply_stimulus(0, 0, 10, 0, 5, 0, -5, 0, mk(-5, 0, 5, 0, 1'b0, 33), 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_output("mid_rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("mid_rst_out_valid", out_valid, 0);
        check_output("mid_rst_nvx0", nvx0, 0);
        check_output("mid_rst_nvy0", nvy0, 0);
        check_output("mid_rst_nvx1", nvx1, 0);
        check_output("mid_rst_nvy1", nvy1, 0);
        check_output("mid_rst_in_ready_after", in_ready, 1);
        apply_stimulus(0, 0, 10, 0, 5, 0, -5, 0, mk(-5, 0, 5, 0, 1'b0, 33), 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
